btb_gshare: RTL and testbench

Parametrised branch predictor for the 5-stage pipeline: a 2-way set-associative branch target buffer (BTB) with valid bits and per-set LRU, plus a gshare pattern history table (PHT) indexed by PC XOR global history. Fetch (IF) gets a same-cycle combinational prediction and target. Execute (EX) resolves branches and trains the tables. Two 32-bit performance counters record resolved branches and mispredictions.

---
 rtl/btb_gshare.sv | 100 ++++++++++
 tb/tb_btb_gshare.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_gshare.sv
// 2-way set-associative BTB with per-set LRU plus a gshare PHT.
// Fetch gets a zero-latency prediction; EX resolution trains tables and counts mispredictions.
module btb_gshare #(
    parameter int SET_BITS = 4,
    parameter int PHT_BITS = 6,
    parameter int GHR_LEN  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    output logic        PredF,
    output logic [31:0] NPC_PredF,
    input  logic [31:0] PCE,
    input  logic        BrE,
    input  logic        BranchE,
    input  logic [31:0] BrNPC,
    input  logic        PredE,
    input  logic [31:0] NPC_PredE,
    output logic [31:0] BrCnt,
    output logic [31:0] MissCnt
);
    localparam int SETS = 1 << SET_BITS;
    localparam int PHTN = 1 << PHT_BITS;

    typedef struct packed {
        logic        v;
        logic [29:0] tag;
        logic [31:0] dst;
    } btb_ent_t;

    btb_ent_t [SETS-1:0][1:0] btb;
    logic [SETS-1:0]          lru;
    logic [PHTN-1:0][1:0]     pht;
    logic [GHR_LEN-1:0]       ghr, ghr_nxt;

    logic [SET_BITS-1:0] set_f, set_e;
    logic [PHT_BITS-1:0] idx_f, idx_e;
    logic [1:0]          hit_f, hit_e;
    logic                way_f, wr_way, miss_e;
    logic                unused_pc;

    assign unused_pc = ^{PCF[1:0], PCE[1:0]};

    assign set_f = PCF[SET_BITS+1:2];
    assign set_e = PCE[SET_BITS+1:2];
    assign idx_f = PCF[PHT_BITS+1:2] ^ PHT_BITS'(ghr);
    assign idx_e = PCE[PHT_BITS+1:2] ^ PHT_BITS'(ghr);

    generate
        if (GHR_LEN == 1) begin : g_ghr1
            assign ghr_nxt = BranchE;
        end else begin : g_ghrn
            assign ghr_nxt = {ghr[GHR_LEN-2:0], BranchE};
        end
    endgenerate

    always_comb begin
        for (int w = 0; w < 2; w++) begin
            hit_f[w] = btb[set_f][w].v && (btb[set_f][w].tag == PCF[31:2]);
            hit_e[w] = btb[set_e][w].v && (btb[set_e][w].tag == PCE[31:2]);
        end
    end

    // Way 0 wins a double match; it cannot arise from writes.
    assign way_f     = ~hit_f[0];
    assign PredF     = (|hit_f) && pht[idx_f][1];
    assign NPC_PredF = PredF ? btb[set_f][way_f].dst : PCF + 32'd4;

    // On a hit the hit way is rewritten in place; otherwise fill invalid ways before using LRU.
    always_comb begin
        if (|hit_e)               wr_way = ~hit_e[0];
        else if (!btb[set_e][0].v) wr_way = 1'b0;
        else if (!btb[set_e][1].v) wr_way = 1'b1;
        else                      wr_way = lru[set_e];
    end

    assign miss_e = (PredE != BranchE) || (BranchE && PredE && (NPC_PredE != BrNPC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btb     <= '0;
            lru     <= '0;
            pht     <= {PHTN{2'b01}};
            ghr     <= '0;
            BrCnt   <= '0;
            MissCnt <= '0;
        end else if (BrE) begin
            if (BranchE) begin
                if (pht[idx_e] != 2'b11) pht[idx_e] <= pht[idx_e] + 2'd1;
                btb[set_e][wr_way] <= btb_ent_t'{v: 1'b1, tag: PCE[31:2], dst: BrNPC};
                lru[set_e]         <= ~wr_way;
            end else if (pht[idx_e] != 2'b00) begin
                pht[idx_e] <= pht[idx_e] - 2'd1;
            end
            ghr     <= ghr_nxt;
            BrCnt   <= BrCnt + 32'd1;
            MissCnt <= MissCnt + 32'(miss_e);
        end
    end
endmodule

// File: tb/tb_btb_gshare.sv
// Scoreboard bench for btb_gshare: a behavioural table model plus hand-derived
// checkpoints feed a queue of expectations that is drained at each negedge.
module tb_btb_gshare;
    localparam int SET_BITS = 4;
    localparam int PHT_BITS = 6;
    localparam int GHR_LEN  = 4;
    localparam int SETS     = 1 << SET_BITS;
    localparam int PHTN     = 1 << PHT_BITS;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF, NPC_PredF, PCE, BrNPC, NPC_PredE, BrCnt, MissCnt;
    logic        PredF, BrE, BranchE, PredE;

    btb_gshare #(.SET_BITS(SET_BITS), .PHT_BITS(PHT_BITS), .GHR_LEN(GHR_LEN)) dut (
        .clk(clk), .rst(rst), .PCF(PCF), .PredF(PredF), .NPC_PredF(NPC_PredF),
        .PCE(PCE), .BrE(BrE), .BranchE(BranchE), .BrNPC(BrNPC), .PredE(PredE),
        .NPC_PredE(NPC_PredE), .BrCnt(BrCnt), .MissCnt(MissCnt)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nmis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;
    exp_t sbq[$];

    task automatic push(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag; e.sel = sel; e.val = val;
        sbq.push_back(e);
    endtask

    function automatic logic [31:0] obs_of(input int sel);
        case (sel)
            0:       return {31'b0, PredF};
            1:       return NPC_PredF;
            2:       return BrCnt;
            default: return MissCnt;
        endcase
    endfunction

    task automatic drain();
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk(e.tag, obs_of(e.sel), e.val);
        end
    endtask

    // Behavioural reference tables
    logic               mv  [SETS][2];
    logic [29:0]        mt  [SETS][2];
    logic [31:0]        md  [SETS][2];
    logic               mlru[SETS];
    logic [1:0]         mpht[PHTN];
    logic [GHR_LEN-1:0] mghr;
    logic [31:0]        mbr, mmiss;

    function automatic void m_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < 2; w++) begin
                mv[s][w] = 1'b0; mt[s][w] = '0; md[s][w] = '0;
            end
            mlru[s] = 1'b0;
        end
        for (int i = 0; i < PHTN; i++) mpht[i] = 2'b01;
        mghr = '0; mbr = '0; mmiss = '0;
    endfunction

    function automatic void m_predict(input logic [31:0] pc, output logic p, output logic [31:0] npc);
        int s, idx;
        logic h0, h1;
        s   = int'(pc[SET_BITS+1:2]);
        idx = int'(pc[PHT_BITS+1:2]) ^ int'(mghr);
        h0  = mv[s][0] && (mt[s][0] == pc[31:2]);
        h1  = mv[s][1] && (mt[s][1] == pc[31:2]);
        p   = (h0 || h1) && mpht[idx][1];
        if (!p)      npc = pc + 32'd4;
        else if (h0) npc = md[s][0];
        else         npc = md[s][1];
    endfunction

    function automatic void m_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                                     input logic pe, input logic [31:0] npce);
        int s, idx, vict;
        s   = int'(pc[SET_BITS+1:2]);
        idx = int'(pc[PHT_BITS+1:2]) ^ int'(mghr);
        mbr = mbr + 1;
        if (pe != tk || (tk && pe && npce != tgt)) mmiss = mmiss + 1;
        if (tk) begin
            if (mpht[idx] < 2'b11) mpht[idx] = mpht[idx] + 2'd1;
            if (mv[s][0] && mt[s][0] == pc[31:2])      vict = 0;
            else if (mv[s][1] && mt[s][1] == pc[31:2]) vict = 1;
            else if (!mv[s][0])                        vict = 0;
            else if (!mv[s][1])                        vict = 1;
            else                                       vict = int'(mlru[s]);
            mv[s][vict] = 1'b1;
            mt[s][vict] = pc[31:2];
            md[s][vict] = tgt;
            mlru[s]     = (vict == 0);
        end else if (mpht[idx] > 2'b00) begin
            mpht[idx] = mpht[idx] - 2'd1;
        end
        mghr = {mghr[GHR_LEN-2:0], tk};
    endfunction

    task automatic hard(input string tag, input logic p, input logic [31:0] npc);
        push({tag, "_pred"}, 0, {31'b0, p});
        push({tag, "_npc"}, 1, npc);
    endtask

    task automatic hard_cnt(input string tag, input logic [31:0] br, input logic [31:0] miss);
        push({tag, "_brcnt"}, 2, br);
        push({tag, "_misscnt"}, 3, miss);
    endtask

    // Entered #1 after a posedge; drives one cycle, checks at negedge, commits model at posedge.
    task automatic step(input logic upd, input logic [31:0] pce, input logic tk, input logic [31:0] tgt,
                        input logic pe, input logic [31:0] npce, input logic [31:0] pcf, input string tag);
        logic        p;
        logic [31:0] n;
        PCF = pcf; BrE = upd; PCE = pce; BranchE = tk; BrNPC = tgt; PredE = pe; NPC_PredE = npce;
        m_predict(pcf, p, n);
        push({tag, "_m_pred"}, 0, {31'b0, p});
        push({tag, "_m_npc"}, 1, n);
        push({tag, "_m_brcnt"}, 2, mbr);
        push({tag, "_m_misscnt"}, 3, mmiss);
        @(negedge clk);
        drain();
        @(posedge clk);
        if (upd) m_update(pce, tk, tgt, pe, npce);
        #1;
        BrE = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pce, input logic tk, input logic [31:0] tgt,
                       input logic pe, input logic [31:0] npce, input logic [31:0] pcf);
        step(1'b1, pce, tk, tgt, pe, npce, pcf, "upd");
    endtask

    task automatic look(input logic [31:0] pcf);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, pcf, "look");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] pool [8];
        logic [31:0] tgts [4];
        pool = '{32'h10, 32'h50, 32'h90, 32'hD0, 32'h14, 32'h30, 32'h110, 32'h1010};
        tgts = '{32'h40, 32'h80, 32'hC0, 32'h100};

        rst = 1'b1; BrE = 1'b0; BranchE = 1'b0; PredE = 1'b0;
        PCF = 32'h100; PCE = '0; BrNPC = '0; NPC_PredE = '0;
        m_reset();
        #2;
        hard("rst", 1'b0, 32'h104); hard_cnt("rst", 0, 0);
        drain();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Same-cycle hazard on the first allocation, then the train loop
        hard("hazard", 1'b0, 32'h14);
        upd(32'h10, 1'b1, 32'h40, 1'b0, 32'h0, 32'h10);
        for (int i = 0; i < 4; i++) upd(32'h10, 1'b1, 32'h40, 1'b0, 32'h0, 32'h10);
        hard("train", 1'b1, 32'h40); hard_cnt("train", 5, 5);
        look(32'h10);

        upd(32'h10, 1'b0, 32'h40, 1'b1, 32'h40, 32'h10);
        hard("untrain", 1'b0, 32'h14); hard_cnt("untrain", 6, 6);
        look(32'h10);

        // Shift history to 0001 and saturate PHT[5] without touching set 4
        for (int i = 0; i < 3; i++) upd(32'h14, 1'b0, 32'h0, 1'b0, 32'h0, 32'h14);
        upd(32'h14, 1'b1, 32'h60, 1'b1, 32'h60, 32'h14);
        hard("revalid", 1'b1, 32'h40); hard_cnt("revalid", 10, 6);
        look(32'h10);

        upd(32'h10, 1'b1, 32'h80, 1'b1, 32'h40, 32'h10);
        hard("tgtchg", 1'b1, 32'h80); hard_cnt("tgtchg", 11, 7);
        look(32'h10);

        // LRU: 0x50 fills way 1, 0x90 evicts 0x10 from way 0
        upd(32'h50, 1'b1, 32'hA0, 1'b0, 32'h0, 32'h50);
        upd(32'h90, 1'b1, 32'hC0, 1'b0, 32'h0, 32'h90);
        upd(32'h90, 1'b1, 32'hC0, 1'b1, 32'hC0, 32'h90);
        upd(32'h90, 1'b1, 32'hC0, 1'b1, 32'hC0, 32'h90);
        hard("lru_90", 1'b1, 32'hC0);
        look(32'h90);
        hard("lru_10gone", 1'b0, 32'h14);
        look(32'h10);
        upd(32'h10, 1'b1, 32'h40, 1'b0, 32'h0, 32'h10);
        hard("lru_90kept", 1'b1, 32'hC0);
        look(32'h90);
        upd(32'h10, 1'b1, 32'h40, 1'b0, 32'h0, 32'h10);
        hard("lru_10back", 1'b1, 32'h40); hard_cnt("lru", 17, 11);
        look(32'h10);

        // Asynchronous reset in the middle of an update cycle
        PCE = 32'h10; BranchE = 1'b1; BrNPC = 32'h40; PredE = 1'b0; BrE = 1'b1; PCF = 32'h100;
        #2 rst = 1'b1;
        #1;
        m_reset();
        hard("midrst", 1'b0, 32'h104); hard_cnt("midrst", 0, 0);
        drain();
        @(posedge clk); #1;
        BrE = 1'b0;
        hard("midrst_edge", 1'b0, 32'h104); hard_cnt("midrst_edge", 0, 0);
        drain();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        hard("postrst_10", 1'b0, 32'h14);
        look(32'h10);
        hard("postrst_90", 1'b0, 32'h94);
        look(32'h90);

        // Random mix biased towards taken branches in a few crowded sets
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(3) != 0), pool[$urandom_range(7)], ($urandom_range(3) != 0),
                 tgts[$urandom_range(3)], 1'($urandom_range(1)), tgts[$urandom_range(3)],
                 pool[$urandom_range(7)], "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
        $finish;
    end
endmodule
